// File: rtl/tri_bus_arbiter.sv
// Round-robin arbiter for a shared tri-state bus: one owner at a time with a released gap between
// owners. Define BUS_KEEPER_EN to make the idle bus_q hold the last driven value.
module tri_bus_arbiter #(
  parameter int unsigned  NCH      = 4,
  parameter int unsigned  W        = 8,
  parameter int unsigned  MAX_HOLD = 8,
  parameter int unsigned  TURN     = 1,
  parameter logic [W-1:0] IDLE_VAL = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NCH-1:0]     req,
  input  logic [NCH*W-1:0]   wdata,
  inout  wire  [W-1:0]       bus,
  output logic [NCH-1:0]     grant,
  output logic               busy,
  output logic [W-1:0]       bus_q,
  output logic               collide
);

  localparam int unsigned IW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {StIdle, StGrant, StTurn} state_e;

  state_e         state_q, state_d;
  logic [IW-1:0]  ptr_q, ptr_d;
  logic [IW-1:0]  owner_q, owner_d;
  logic [7:0]     hold_q, hold_d;
  logic [2:0]     turn_q, turn_d;
  logic [NCH-1:0] grant_q, grant_d;
  logic [W-1:0]   sample_q;
  logic           collide_q;

  logic           found;
  logic           arb;
  logic [IW-1:0]  pick;
  logic [IW-1:0]  cand;
  logic [W-1:0]   drive_data;
  logic [W-1:0]   idle_val;
  logic           driving;

  // First requester at or after the round-robin pointer, searching cyclically.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      cand = IW'((32'(ptr_q) + k) % NCH);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      owner_q <= '0;
      hold_q  <= '0;
      turn_q  <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      hold_q  <= hold_d;
      turn_q  <= turn_d;
      grant_q <= grant_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    hold_d  = hold_q;
    turn_d  = turn_q;
    grant_d = grant_q;
    arb     = 1'b0;
    unique case (state_q)
      StIdle: arb = 1'b1;
      StGrant: begin
        if (!req[owner_q] || hold_q == 8'(MAX_HOLD)) begin
          grant_d = '0;
          state_d = StTurn;
          ptr_d   = (owner_q == IW'(NCH - 1)) ? '0 : owner_q + 1'b1;
          hold_d  = '0;
          turn_d  = 3'd1;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      StTurn: begin
        // Arbitration happens in the last released cycle so the gap is exactly TURN cycles.
        if (turn_q == 3'(TURN)) arb = 1'b1;
        else turn_d = turn_q + 3'd1;
      end
      default: state_d = StIdle;
    endcase
    if (arb) begin
      if (found) begin
        state_d = StGrant;
        owner_d = pick;
        grant_d = NCH'(1) << pick;
        hold_d  = 8'd1;
      end else begin
        state_d = StIdle;
      end
    end
  end

  always_comb begin
    busy       = (state_q != StIdle);
    grant      = grant_q;
    driving    = |grant_q;
    drive_data = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (grant_q[i]) drive_data = drive_data | wdata[i*W +: W];
    end
  end

  // grant_q clears asynchronously on reset, so the bus releases without waiting for a clock.
  assign bus = driving ? drive_data : {W{1'bz}};

`ifdef BUS_KEEPER_EN
  logic [W-1:0] keep_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) keep_q <= IDLE_VAL;
    else if (driving) keep_q <= drive_data;
  end

  assign idle_val = keep_q;
`else
  assign idle_val = IDLE_VAL;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_q  <= IDLE_VAL;
      collide_q <= 1'b0;
    end else begin
      sample_q  <= driving ? bus : idle_val;
      collide_q <= collide_q | (driving && (bus !== drive_data));
    end
  end

  assign bus_q   = sample_q;
  assign collide = collide_q;

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Bench for tri_bus_arbiter: directed scenarios plus randomized requests checked against an
// integer-level ownership model.
module tb_tri_bus_arbiter;

  localparam int NCH  = 4;
  localparam int W    = 8;
  localparam int MAXH = 2;
  localparam int TRN  = 1;
  localparam logic [7:0] IDLE = 8'h00;
`ifdef BUS_KEEPER_EN
  localparam bit KEEP = 1'b1;
`else
  localparam bit KEEP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] wdata = '0;
  wire  [7:0]  bus;
  logic [3:0]  grant;
  logic        busy;
  logic [7:0]  bus_q;
  logic        collide;
  logic        tb_en = 1'b0;
  logic [7:0]  tb_val = '0;

  int n_vec = 0;
  int n_err = 0;

  assign bus = tb_en ? tb_val : 8'bz;

  always #5 clk = ~clk;

  tri_bus_arbiter #(
    .NCH(NCH), .W(W), .MAX_HOLD(MAXH), .TURN(TRN), .IDLE_VAL(IDLE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .wdata(wdata), .bus(bus),
    .grant(grant), .busy(busy), .bus_q(bus_q), .collide(collide)
  );

  // Reference model: owner index (-1 = none), cycles held, rr pointer, released cycles left.
  int         m_owner, m_hold, m_ptr, m_gap;
  logic [7:0] m_busq, m_keep;

  task automatic model_reset();
    m_owner = -1; m_hold = 0; m_ptr = 0; m_gap = 0;
    m_busq = IDLE; m_keep = IDLE;
  endtask

  task automatic model_tick();
    int no, nh, np, ng, idx;
    logic [7:0] nb, nk;
    no = m_owner; nh = m_hold; np = m_ptr; ng = m_gap; nk = m_keep;
    if (m_owner >= 0) begin
      nb = wdata[m_owner*W +: W];
      nk = nb;
      if (!req[m_owner] || m_hold == MAXH) begin
        no = -1; np = (m_owner + 1) % NCH; ng = TRN;
      end else begin
        nh = m_hold + 1;
      end
    end else begin
      nb = KEEP ? m_keep : IDLE;
      if (m_gap > 1) ng = m_gap - 1;
      else begin
        ng = 0;
        for (int k = 0; k < NCH; k++) begin
          idx = (m_ptr + k) % NCH;
          if (no < 0 && req[idx]) begin no = idx; nh = 1; end
        end
      end
    end
    m_owner = no; m_hold = nh; m_ptr = np; m_gap = ng; m_busq = nb; m_keep = nk;
  endtask

  function automatic logic [3:0] m_grant();
    return (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0;
  endfunction

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    model_tick();
    edge1();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; tb_en = 1'b0; req = '0;
    edge1();
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 4'b1111; wdata = 32'h1234_5678;
    edge1(); edge1();
    n_vec++; if (grant !== 4'b0) begin n_err++; $display("FAIL reset_grant got %b want 0000", grant); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_vec++; if (bus_q !== IDLE) begin n_err++; $display("FAIL reset_bus_q got %h want %h", bus_q, IDLE); end
    n_vec++; if (collide !== 1'b0) begin n_err++; $display("FAIL reset_collide got %b want 0", collide); end
    rst_n = 1'b1; req = '0;
    model_reset();
  endtask

  task automatic test_single();
    logic [3:0] eg [4] = '{4'b0010, 4'b0010, 4'b0000, 4'b0000};
    logic       eb [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0] eq [4];
    eq[0] = IDLE; eq[1] = 8'hA5; eq[2] = 8'hA5; eq[3] = KEEP ? 8'hA5 : IDLE;
    do_reset();
    wdata = 32'h0000_A500; req = 4'b0010;
    for (int c = 0; c < 4; c++) begin
      edge1();
      if (c == 2) req = 4'b0000;
      n_vec++; if (grant !== eg[c]) begin n_err++; $display("FAIL single_grant[%0d] got %b want %b", c, grant, eg[c]); end
      n_vec++; if (busy !== eb[c]) begin n_err++; $display("FAIL single_busy[%0d] got %b want %b", c, busy, eb[c]); end
      n_vec++; if (bus_q !== eq[c]) begin n_err++; $display("FAIL single_bus_q[%0d] got %h want %h", c, bus_q, eq[c]); end
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] eg [13] = '{4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0100,
                            4'b0100, 4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0001};
    do_reset();
    wdata = 32'h4433_2211; req = 4'b1111;
    for (int c = 0; c < 13; c++) begin
      edge1();
      n_vec++; if (grant !== eg[c]) begin n_err++; $display("FAIL rr_grant[%0d] got %b want %b", c, grant, eg[c]); end
    end
    req = '0;
  endtask

  task automatic test_keeper();
    logic [7:0] want;
    want = KEEP ? 8'h3C : IDLE;
    do_reset();
    wdata = 32'h0000_003C; req = 4'b0001;
    edge1();
    n_vec++; if (bus !== 8'h3C) begin n_err++; $display("FAIL keeper_bus got %h want 3c", bus); end
    req = 4'b0000;
    edge1();
    n_vec++; if (bus_q !== 8'h3C) begin n_err++; $display("FAIL keeper_last got %h want 3c", bus_q); end
    wdata = 32'hFFFF_FF99;
    for (int c = 0; c < 3; c++) begin
      edge1();
      n_vec++; if (bus_q !== want) begin n_err++; $display("FAIL keeper_idle[%0d] got %h want %h", c, bus_q, want); end
    end
  endtask

  task automatic test_collide();
    do_reset();
    wdata = 32'h0000_0000; req = 4'b0001;
    edge1();
    n_vec++; if (collide !== 1'b0) begin n_err++; $display("FAIL collide_pre got %b want 0", collide); end
    tb_en = 1'b1; tb_val = 8'hFF;
    edge1();
    tb_en = 1'b0; req = 4'b0000;
    n_vec++; if (collide !== 1'b1) begin n_err++; $display("FAIL collide_set got %b want 1", collide); end
    repeat (4) edge1();
    n_vec++; if (collide !== 1'b1) begin n_err++; $display("FAIL collide_sticky got %b want 1", collide); end
    do_reset();
    n_vec++; if (collide !== 1'b0) begin n_err++; $display("FAIL collide_clear got %b want 0", collide); end
  endtask

  task automatic test_async_reset();
    do_reset();
    wdata = 32'h005A_0000; req = 4'b0100;
    edge1();
    n_vec++; if (grant !== 4'b0100) begin n_err++; $display("FAIL ar_grant got %b want 0100", grant); end
    n_vec++; if (bus !== 8'h5A) begin n_err++; $display("FAIL ar_bus got %h want 5a", bus); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (grant !== 4'b0) begin n_err++; $display("FAIL ar_release got %b want 0000", grant); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL ar_busy got %b want 0", busy); end
    n_vec++; if (bus === 8'h5A) begin n_err++; $display("FAIL ar_bus_release got %h want z", bus); end
    edge1();
    rst_n = 1'b1; req = 4'b0101;
    edge1();
    n_vec++; if (grant !== 4'b0001) begin n_err++; $display("FAIL ar_first got %b want 0001", grant); end
    req = '0;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 2) == 0) req = 4'($urandom);
      if ($urandom_range(0, 9) == 0) req = 4'b0;
      wdata = $urandom;
      tick();
      n_vec++; if (grant !== m_grant()) begin n_err++; $display("FAIL rnd_grant[%0d] got %b want %b", c, grant, m_grant()); end
      n_vec++; if (busy !== (m_owner >= 0 || m_gap > 0)) begin n_err++; $display("FAIL rnd_busy[%0d] got %b", c, busy); end
      n_vec++; if (bus_q !== m_busq) begin n_err++; $display("FAIL rnd_bus_q[%0d] got %h want %h", c, bus_q, m_busq); end
      n_vec++; if (collide !== 1'b0) begin n_err++; $display("FAIL rnd_collide[%0d] got %b want 0", c, collide); end
      if (m_owner >= 0) begin
        n_vec++;
        if (bus !== wdata[m_owner*W +: W]) begin
          n_err++; $display("FAIL rnd_bus[%0d] got %h want %h", c, bus, wdata[m_owner*W +: W]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_keeper();
    test_collide();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
